// File: rtl/prime_sieve_pkg.sv
// Shared definitions for the prime sieve engine.
//  state_t      : top-level sequencer states
//  phase_t      : sub-phase used inside SIEVE and SEEK
//  clamp_limit  : saturates the requested limit to the largest supported value
package prime_sieve_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, SIEVE, COUNT, SEEK, READY} state_t;

  typedef enum logic [1:0] {PH_ISSUE, PH_WAIT, PH_MARK} phase_t;

  function automatic int unsigned clamp_limit(input int unsigned lim, input int unsigned n_max);
    return (lim > n_max) ? n_max : lim;
  endfunction

endpackage

// File: rtl/mem_rd_align.sv
// Read-latency alignment shift register for the mark RAM.
// Carries {valid, address} for every issued read so the response that
// appears on mem_rdata RD_LAT cycles later arrives tagged with its address.
//  clk, reset         : clock, synchronous active-high reset (drops in-flight reads)
//  req_vld, req_addr  : read issued this cycle
//  rsp_vld, rsp_addr  : read whose data is on mem_rdata this cycle
//  pend               : any read still in flight (including the one responding now)
module mem_rd_align
  import prime_sieve_pkg::*;
#(
  parameter int AW     = 20,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_vld,
  input  logic [AW-1:0] req_addr,
  output logic          rsp_vld,
  output logic [AW-1:0] rsp_addr,
  output logic          pend
);

  logic [RD_LAT-1:0] vld_p;
  logic [AW-1:0]     addr_p [RD_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= req_vld;
      for (int k = 1; k < RD_LAT; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    addr_p[0] <= req_addr;
    for (int k = 1; k < RD_LAT; k++) addr_p[k] <= addr_p[k-1];
  end

  assign rsp_vld  = vld_p[RD_LAT-1];
  assign rsp_addr = addr_p[RD_LAT-1];
  assign pend     = |vld_p;

endmodule

// File: rtl/prime_sieve_seq.sv
// Sieve-of-Eratosthenes engine with prime enumerator over an external 1-bit
// mark RAM (1 = composite). start clears and sieves [0,L], counts primes,
// then seeks the first prime; each step pulse in READY seeks the next one.
//  clk, reset           : clock, synchronous active-high reset
//  start, limit, descend: launch a run; limit and direction sampled on start
//  step                 : advance to next prime (READY only)
//  busy, ready          : sequencer status
//  prime_out/valid      : current prime and its update pulse
//  prime_count, at_end  : number of primes in [2,L]; no further prime
//  mem_we/waddr/wdata   : RAM write port
//  mem_raddr, mem_rdata : RAM read port, RD_LAT cycles latency
module prime_sieve_seq
  import prime_sieve_pkg::*;
#(
  parameter int N_MAX  = 999999,
  parameter int AW     = 20,
  parameter int RD_LAT = 2,
  parameter bit WRAP   = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] limit,
  input  logic          descend,
  input  logic          step,
  output logic          busy,
  output logic          ready,
  output logic [AW-1:0] prime_out,
  output logic          prime_valid,
  output logic [AW-1:0] prime_count,
  output logic          at_end,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic          mem_wdata,
  output logic [AW-1:0] mem_raddr,
  input  logic          mem_rdata
);

  state_t state, state_nxt;
  phase_t ph;

  logic [AW-1:0]   lim, i_r;
  // One extra bit so "one past L" and "one below 0" are representable.
  logic [AW:0]     addr_r, j_r, cursor, lim_x, seek_first;
  logic            desc_r;
  logic [2*AW-1:0] sq;
  logic            rd_req, rsp_vld, rd_pend;
  logic [AW-1:0]   rsp_addr;
  logic            sieve_done, mark_last, cnt_iss, seek_out, lim_small;

  mem_rd_align #(.AW(AW), .RD_LAT(RD_LAT)) u_align (
    .clk      (clk),
    .reset    (reset),
    .req_vld  (rd_req),
    .req_addr (mem_raddr),
    .rsp_vld  (rsp_vld),
    .rsp_addr (rsp_addr),
    .pend     (rd_pend)
  );

  assign lim_x      = {1'b0, lim};
  assign sq         = {{AW{1'b0}}, i_r} * {{AW{1'b0}}, i_r};
  assign sieve_done = sq > {{AW{1'b0}}, lim};
  assign mark_last  = (j_r + {1'b0, i_r}) > lim_x;
  assign cnt_iss    = addr_r <= lim_x;
  assign lim_small  = lim < AW'(2);
  assign seek_out   = desc_r ? (cursor < (AW+1)'(2)) : (cursor > lim_x);
  assign seek_first = desc_r ? lim_x : (AW+1)'(2);

  assign busy  = (state == CLEAR) || (state == SIEVE) || (state == COUNT) || (state == SEEK);
  assign ready = (state == READY);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = 1'b0;
    mem_raddr = '0;
    rd_req    = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CLEAR;
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = addr_r[AW-1:0];
        if (addr_r == lim_x) state_nxt = SIEVE;
      end
      SIEVE: begin
        case (ph)
          PH_ISSUE: begin
            if (sieve_done) state_nxt = COUNT;
            else begin
              rd_req    = 1'b1;
              mem_raddr = i_r;
            end
          end
          PH_MARK: begin
            mem_we    = 1'b1;
            mem_waddr = j_r[AW-1:0];
            mem_wdata = 1'b1;
          end
          default: ;
        endcase
      end
      COUNT: begin
        if (cnt_iss) begin
          rd_req    = 1'b1;
          mem_raddr = addr_r[AW-1:0];
        end else if (!rd_pend) begin
          state_nxt = SEEK;
        end
      end
      SEEK: begin
        if (ph == PH_ISSUE) begin
          // With WRAP an out-of-range cursor just restarts; L<2 has no prime at all.
          if (lim_small || (seek_out && !WRAP)) state_nxt = READY;
          else if (!seek_out) begin
            rd_req    = 1'b1;
            mem_raddr = cursor[AW-1:0];
          end
        end else if (rsp_vld && !mem_rdata) begin
          state_nxt = READY;
        end
      end
      READY: begin
        if (start)     state_nxt = CLEAR;
        else if (step) state_nxt = SEEK;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ph          <= PH_ISSUE;
      prime_valid <= 1'b0;
      prime_out   <= '0;
      prime_count <= '0;
      at_end      <= 1'b0;
    end else begin
      prime_valid <= 1'b0;
      case (state)
        IDLE, READY: begin
          if (start) begin
            lim         <= AW'(clamp_limit(32'(limit), 32'(N_MAX)));
            desc_r      <= descend;
            addr_r      <= '0;
            at_end      <= 1'b0;
            prime_out   <= '0;
            prime_count <= '0;
          end else if ((state == READY) && step) begin
            cursor <= desc_r ? ({1'b0, prime_out} - (AW+1)'(1))
                             : ({1'b0, prime_out} + (AW+1)'(1));
            ph     <= PH_ISSUE;
          end
        end
        // CLEAR -> SIEVE
        CLEAR: begin
          addr_r <= addr_r + (AW+1)'(1);
          if (addr_r == lim_x) begin
            i_r <= AW'(2);
            ph  <= PH_ISSUE;
          end
        end
        // SIEVE -> COUNT
        SIEVE: begin
          case (ph)
            PH_ISSUE: begin
              if (sieve_done) addr_r <= (AW+1)'(2);
              else            ph     <= PH_WAIT;
            end
            PH_WAIT: begin
              if (rsp_vld) begin
                if (!mem_rdata) begin
                  j_r <= sq[AW:0];
                  ph  <= PH_MARK;
                end else begin
                  i_r <= i_r + AW'(1);
                  ph  <= PH_ISSUE;
                end
              end
            end
            PH_MARK: begin
              if (mark_last) begin
                i_r <= i_r + AW'(1);
                ph  <= PH_ISSUE;
              end else begin
                j_r <= j_r + {1'b0, i_r};
              end
            end
            default: ph <= PH_ISSUE;
          endcase
        end
        // COUNT -> SEEK
        COUNT: begin
          if (cnt_iss) addr_r <= addr_r + (AW+1)'(1);
          if (rsp_vld && !mem_rdata) prime_count <= prime_count + AW'(1);
          if (!cnt_iss && !rd_pend) begin
            cursor <= seek_first;
            ph     <= PH_ISSUE;
          end
        end
        // SEEK -> READY
        SEEK: begin
          if (ph == PH_ISSUE) begin
            if (lim_small) at_end <= 1'b1;
            else if (seek_out) begin
              if (WRAP) cursor <= seek_first;
              else      at_end <= 1'b1;
            end else begin
              ph <= PH_WAIT;
            end
          end else if (rsp_vld) begin
            if (!mem_rdata) begin
              prime_out   <= rsp_addr;
              prime_valid <= 1'b1;
            end else begin
              cursor <= desc_r ? (cursor - (AW+1)'(1)) : (cursor + (AW+1)'(1));
              ph     <= PH_ISSUE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
